qpll_reset_sequencer: RTL and testbench

//  Power-up, reset and lock supervisor for the GTX quad PLL (GTXE2_COMMON). Drives QPLLPD/QPLLRESET.

---
 rtl/qpll_reset_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_qpll_reset_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpll_reset_sequencer.sv
// Power-up, reset and lock supervisor for the GTX quad PLL.
// Sequences QPLLPD/QPLLRESET, qualifies lock, retries and faults.

module qpll_reset_sequencer #(
    parameter int PD_CYCLES    = 64,
    parameter int RESET_CYCLES = 32,
    parameter int LOCK_TIMEOUT = 125000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 7
) (
    input  logic       clk_125mhz,
    input  logic       rst_n,
    input  logic       start,
    input  logic       qpll_lock,
    input  logic       qpll_refclk_lost,
    output logic       qpll_pd,
    output logic       qpll_reset,
    output logic       qpll_ready,
    output logic       fault,
    output logic [7:0] retry_count,
    output logic [2:0] state
);

    localparam int MAX_A = (PD_CYCLES > RESET_CYCLES) ? PD_CYCLES : RESET_CYCLES;
    localparam int MAX_B = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t       PD_LAST   = cnt_t'(PD_CYCLES - 1);
    localparam cnt_t       RST_LAST  = cnt_t'(RESET_CYCLES - 1);
    localparam cnt_t       TO_LAST   = cnt_t'(LOCK_TIMEOUT - 1);
    localparam cnt_t       ST_LAST   = cnt_t'(LOCK_STABLE - 1);
    localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PWRDN     = 3'd1,
        RESET     = 3'd2,
        WAIT_LOCK = 3'd3,
        STABLE    = 3'd4,
        READY     = 3'd5,
        FAULT     = 3'd6
    } state_t;

    state_t     state_q, state_d;
    cnt_t       tmr_q, tmr_d;
    cnt_t       to_q, to_d;
    cnt_t       st_q, st_d;
    logic [7:0] retry_q, retry_d, retry_inc;
    logic       fail;
    logic       lock_m, lock_s, lost_m, lost_s;
    logic       pd_q, rst_q, rdy_q, flt_q;
    logic       pd_d, rst_d, rdy_d, flt_d;

    // Bring the asynchronous PLL status pins into the clock domain
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            lost_m <= 1'b0;
            lost_s <= 1'b0;
        end else begin
            lock_m <= qpll_lock;
            lock_s <= lock_m;
            lost_m <= qpll_refclk_lost;
            lost_s <= lost_m;
        end
    end

    // State, timers, retry count and registered outputs
    always_ff @(posedge clk_125mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            to_q    <= '0;
            st_q    <= '0;
            retry_q <= 8'd0;
            pd_q    <= 1'b1;
            rst_q   <= 1'b1;
            rdy_q   <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            to_q    <= to_d;
            st_q    <= st_d;
            retry_q <= retry_d;
            pd_q    <= pd_d;
            rst_q   <= rst_d;
            rdy_q   <= rdy_d;
            flt_q   <= flt_d;
        end
    end

    // Next state; priority is start, refclk loss, timeout, then lock
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        to_d      = to_q;
        st_d      = st_q;
        retry_d   = retry_q;
        fail      = 1'b0;
        retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
        unique case (state_q)
            IDLE: begin
                state_d = PWRDN;
                tmr_d   = '0;
            end
            PWRDN: begin
                if (lost_s) begin
                    tmr_d = '0;
                end else if (tmr_q == PD_LAST) begin
                    state_d = RESET;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RESET: begin
                if (lost_s) begin
                    fail = 1'b1;
                end else if (tmr_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    to_d    = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                to_d = to_q + 1'b1;
                if (lost_s || to_q == TO_LAST) begin
                    fail = 1'b1;
                end else if (lock_s) begin
                    state_d = STABLE;
                    st_d    = '0;
                end
            end
            STABLE: begin
                to_d = to_q + 1'b1;
                if (lost_s || to_q == TO_LAST) begin
                    fail = 1'b1;
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (st_q == ST_LAST) begin
                    state_d = READY;
                end else begin
                    st_d = st_q + 1'b1;
                end
            end
            READY: begin
                if (!lock_s || lost_s) begin
                    state_d = PWRDN;
                    tmr_d   = '0;
                    retry_d = 8'd0;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (fail) begin
            retry_d = retry_inc;
            tmr_d   = '0;
            state_d = (retry_inc == RETRY_LIM) ? FAULT : PWRDN;
        end
        if (start) begin
            state_d = PWRDN;
            retry_d = 8'd0;
            tmr_d   = '0;
            to_d    = '0;
            st_d    = '0;
        end
    end

    // Decode outputs from the next state so they move with the state
    always_comb begin
        pd_d  = 1'b0;
        rst_d = 1'b0;
        rdy_d = 1'b0;
        flt_d = 1'b0;
        unique case (state_d)
            IDLE, PWRDN: begin
                pd_d  = 1'b1;
                rst_d = 1'b1;
            end
            RESET: rst_d = 1'b1;
            READY: rdy_d = 1'b1;
            FAULT: begin
                pd_d  = 1'b1;
                rst_d = 1'b1;
                flt_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign qpll_pd     = pd_q;
    assign qpll_reset  = rst_q;
    assign qpll_ready  = rdy_q;
    assign fault       = flt_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_qpll_reset_sequencer.sv
// Self-checking bench for qpll_reset_sequencer.
// Deadline-based reference model plus scenario timing checks.

module tb_qpll_reset_sequencer;

    localparam int PD  = 4;
    localparam int RST = 4;
    localparam int TO  = 20;
    localparam int ST  = 8;
    localparam int MR  = 2;
    localparam logic [14:0] RST_VEC = 15'h6000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       qpll_lock = 1'b0;
    logic       qpll_refclk_lost = 1'b0;
    logic       qpll_pd, qpll_reset, qpll_ready, fault;
    logic [7:0] retry_count;
    logic [2:0] state;

    int n_run = 0;
    int n_fail = 0;

    qpll_reset_sequencer #(
        .PD_CYCLES(PD), .RESET_CYCLES(RST), .LOCK_TIMEOUT(TO),
        .LOCK_STABLE(ST), .MAX_RETRY(MR)
    ) dut (
        .clk_125mhz(clk), .rst_n(rst_n), .start(start),
        .qpll_lock(qpll_lock), .qpll_refclk_lost(qpll_refclk_lost),
        .qpll_pd(qpll_pd), .qpll_reset(qpll_reset),
        .qpll_ready(qpll_ready), .fault(fault),
        .retry_count(retry_count), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: phases with absolute edge deadlines
    int   ec = 0;
    int   pd_dl = 0, rs_dl = 0, to_dl = 0, st_dl = 0;
    int   m_retry = 0, m_ph = 0;
    logic l1 = 1'b0, l2 = 1'b0, c1 = 1'b0, c2 = 1'b0;
    logic [14:0] dut_vec, mexp;

    function automatic int sat(input int r);
        return (r >= 255) ? 255 : r + 1;
    endfunction

    function automatic int fail_ph(input int r);
        return (sat(r) == MR) ? 6 : 1;
    endfunction

    assign dut_vec = {qpll_pd, qpll_reset, qpll_ready, fault, retry_count, state};
    assign mexp = {(m_ph == 0 || m_ph == 1 || m_ph == 6),
                   (m_ph <= 2 || m_ph == 6),
                   (m_ph == 5), (m_ph == 6),
                   8'(m_retry), 3'(m_ph)};

    // Model advances on each edge; seen inputs lag the pins by two edges
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ec <= 0; m_ph <= 0; m_retry <= 0;
            l1 <= 1'b0; l2 <= 1'b0; c1 <= 1'b0; c2 <= 1'b0;
        end else begin
            ec <= ec + 1;
            l1 <= qpll_lock; l2 <= l1;
            c1 <= qpll_refclk_lost; c2 <= c1;
            if (start) begin
                m_ph <= 1; m_retry <= 0; pd_dl <= ec + PD;
            end else begin
                case (m_ph)
                    0: begin m_ph <= 1; pd_dl <= ec + PD; end
                    1: begin
                        if (c2) pd_dl <= ec + PD;
                        else if (ec == pd_dl) begin m_ph <= 2; rs_dl <= ec + RST; end
                    end
                    2: begin
                        if (c2) begin
                            m_retry <= sat(m_retry); m_ph <= fail_ph(m_retry); pd_dl <= ec + PD;
                        end else if (ec == rs_dl) begin
                            m_ph <= 3; to_dl <= ec + TO;
                        end
                    end
                    3: begin
                        if (c2 || ec == to_dl) begin
                            m_retry <= sat(m_retry); m_ph <= fail_ph(m_retry); pd_dl <= ec + PD;
                        end else if (l2) begin
                            m_ph <= 4; st_dl <= ec + ST;
                        end
                    end
                    4: begin
                        if (c2 || ec == to_dl) begin
                            m_retry <= sat(m_retry); m_ph <= fail_ph(m_retry); pd_dl <= ec + PD;
                        end else if (!l2) m_ph <= 3;
                        else if (ec == st_dl) m_ph <= 5;
                    end
                    5: begin
                        if (!l2 || c2) begin m_ph <= 1; m_retry <= 0; pd_dl <= ec + PD; end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; qpll_lock = 1'b0; qpll_refclk_lost = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_run++;
            if (dut_vec !== RST_VEC) begin
                n_fail++;
                $display("FAIL reset i=%0d got=%h exp=%h", i, dut_vec, RST_VEC);
            end
        end
    endtask

    task automatic test_nominal;
        int lk = 9 + int'($urandom_range(0, 6));
        int r = lk + 3 + ST;
        rst_n = 1'b1;
        for (int e = 1; e <= r + 5; e++) begin
            qpll_lock = (e > lk);
            @(posedge clk); #1;
            n_run++;
            if (dut_vec !== mexp) begin
                n_fail++;
                $display("FAIL nominal e=%0d got=%h exp=%h", e, dut_vec, mexp);
            end
            if (e == PD || e == PD + 1) begin
                n_run++;
                if (qpll_pd !== (e == PD)) begin
                    n_fail++;
                    $display("FAIL nominal_pd e=%0d got=%b exp=%b", e, qpll_pd, (e == PD));
                end
            end
            if (e == PD + RST || e == PD + RST + 1) begin
                n_run++;
                if (qpll_reset !== (e == PD + RST)) begin
                    n_fail++;
                    $display("FAIL nominal_rst e=%0d got=%b exp=%b", e, qpll_reset, (e == PD + RST));
                end
            end
            if (e == r - 1 || e == r) begin
                n_run++;
                if ({qpll_ready, fault, retry_count} !== {(e == r), 1'b0, 8'd0}) begin
                    n_fail++;
                    $display("FAIL nominal_ready e=%0d got=%b exp=%b", e, qpll_ready, (e == r));
                end
            end
        end
    endtask

    task automatic test_never_lock;
        int f1 = 1 + PD + RST + TO;
        int f2 = f1 + PD + RST + TO;
        for (int e = 1; e <= 75; e++) begin
            start = (e == 1);
            qpll_lock = 1'b0;
            @(posedge clk); #1;
            n_run++;
            if (dut_vec !== mexp) begin
                n_fail++;
                $display("FAIL never_lock e=%0d got=%h exp=%h", e, dut_vec, mexp);
            end
            if (e == f1 - 1 || e == f1) begin
                n_run++;
                if ({retry_count, state} !== ((e == f1) ? {8'd1, 3'd1} : {8'd0, 3'd3})) begin
                    n_fail++;
                    $display("FAIL retry1 e=%0d got=%0d/%0d", e, retry_count, state);
                end
            end
            if (e == f2 || e == 75) begin
                n_run++;
                if ({qpll_pd, qpll_reset, fault, retry_count, state} !== {3'b111, 8'd2, 3'd6}) begin
                    n_fail++;
                    $display("FAIL fault_hold e=%0d got=%b%b%b/%0d/%0d exp=111/2/6",
                             e, qpll_pd, qpll_reset, fault, retry_count, state);
                end
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_run++;
        if ({fault, retry_count, state} !== {1'b0, 8'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL fault_clear got=%b/%0d/%0d exp=0/0/1", fault, retry_count, state);
        end
    endtask

    task automatic test_glitch;
        int lk = int'($urandom_range(7, 13));
        int s = (lk + 3 > 10) ? lk + 3 : 10;
        int g = s + 3;
        int f1 = 1 + PD + RST + TO;
        int r = (g + 1 + ST + 3 < f1) ? g + 1 + ST + 3 : f1 + PD + RST + 1 + ST;
        for (int e = 1; e <= r + 4; e++) begin
            start = (e == 1);
            qpll_lock = (e > lk) && (e != g + 1);
            @(posedge clk); #1;
            n_run++;
            if (dut_vec !== mexp) begin
                n_fail++;
                $display("FAIL glitch e=%0d got=%h exp=%h", e, dut_vec, mexp);
            end
            if (e == g + 3) begin
                n_run++;
                if ({qpll_reset, state} !== {1'b0, 3'd3}) begin
                    n_fail++;
                    $display("FAIL glitch_wait e=%0d got=%b/%0d exp=0/3", e, qpll_reset, state);
                end
            end
            if (e == r - 1 || e == r) begin
                n_run++;
                if ({qpll_ready, retry_count} !== {(e == r), 8'((r > f1) ? 1 : 0)}) begin
                    n_fail++;
                    $display("FAIL glitch_ready e=%0d got=%b/%0d exp=%b", e, qpll_ready, retry_count, (e == r));
                end
            end
        end
    endtask

    task automatic test_refclk_loss;
        int a = 20 + int'($urandom_range(0, 4));
        int d = int'($urandom_range(8, 12));
        for (int e = 1; e <= a + d + 24; e++) begin
            start = (e == 1);
            qpll_lock = 1'b1;
            qpll_refclk_lost = (e > a) && (e <= a + d);
            @(posedge clk); #1;
            n_run++;
            if (dut_vec !== mexp) begin
                n_fail++;
                $display("FAIL refclk e=%0d got=%h exp=%h", e, dut_vec, mexp);
            end
            if (e == a + 2 || e == a + 3) begin
                n_run++;
                if ({qpll_ready, qpll_pd} !== ((e == a + 2) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL refclk_drop e=%0d got=%b%b", e, qpll_ready, qpll_pd);
                end
            end
            if (e == a + d + 5 || e == a + d + 6) begin
                n_run++;
                if (qpll_pd !== (e == a + d + 5)) begin
                    n_fail++;
                    $display("FAIL refclk_pd e=%0d got=%b exp=%b", e, qpll_pd, (e == a + d + 5));
                end
            end
            if (e == a + d + 18 || e == a + d + 19) begin
                n_run++;
                if ({qpll_ready, retry_count} !== {(e == a + d + 19), 8'd0}) begin
                    n_fail++;
                    $display("FAIL refclk_relock e=%0d got=%b/%0d", e, qpll_ready, retry_count);
                end
            end
        end
        qpll_refclk_lost = 1'b0;
    endtask

    task automatic test_start;
        int sb = int'($urandom_range(11, 17));
        int fb = 60 + int'($urandom_range(0, 5));
        for (int e = 1; e <= sb + 20; e++) begin
            start = (e == 1) || (e == sb);
            qpll_lock = 1'b1;
            @(posedge clk); #1;
            n_run++;
            if (dut_vec !== mexp) begin
                n_fail++;
                $display("FAIL start_stable e=%0d got=%h exp=%h", e, dut_vec, mexp);
            end
            if (e == sb - 1 || e == sb) begin
                n_run++;
                if ({qpll_ready, state} !== ((e == sb) ? {1'b0, 3'd1} : {1'b0, 3'd4})) begin
                    n_fail++;
                    $display("FAIL start_stable_st e=%0d got=%b/%0d", e, qpll_ready, state);
                end
            end
            if (e == sb + 17) begin
                n_run++;
                if (qpll_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_stable_ready e=%0d got=%b exp=1", e, qpll_ready);
                end
            end
        end
        for (int e = 1; e <= fb + 15; e++) begin
            start = (e == 1) || (e >= fb && e <= fb + 2);
            qpll_lock = 1'b0;
            @(posedge clk); #1;
            n_run++;
            if (dut_vec !== mexp) begin
                n_fail++;
                $display("FAIL start_fault e=%0d got=%h exp=%h", e, dut_vec, mexp);
            end
            if (e == fb - 1) begin
                n_run++;
                if ({fault, state} !== {1'b1, 3'd6}) begin
                    n_fail++;
                    $display("FAIL start_fault_pre e=%0d got=%b/%0d exp=1/6", e, fault, state);
                end
            end
            if (e >= fb && e <= fb + 2) begin
                n_run++;
                if ({fault, qpll_ready, retry_count, state} !== {2'b00, 8'd0, 3'd1}) begin
                    n_fail++;
                    $display("FAIL start_fault_clr e=%0d got=%b%b/%0d/%0d", e, fault, qpll_ready, retry_count, state);
                end
            end
            if (e == fb + 2 + PD) begin
                n_run++;
                if (state !== 3'd2) begin
                    n_fail++;
                    $display("FAIL start_held e=%0d got=%0d exp=2", e, state);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset;
        for (int e = 1; e <= 12; e++) begin
            start = (e == 1);
            qpll_lock = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_run++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL async_pre got=%0d exp=3", state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (dut_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_now got=%h exp=%h", dut_vec, RST_VEC);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_run++;
            if (dut_vec !== RST_VEC) begin
                n_fail++;
                $display("FAIL async_hold i=%0d got=%h exp=%h", i, dut_vec, RST_VEC);
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            qpll_lock = (e > 5);
            @(posedge clk); #1;
            n_run++;
            if (dut_vec !== mexp) begin
                n_fail++;
                $display("FAIL async_seq e=%0d got=%h exp=%h", e, dut_vec, mexp);
            end
            if (e == 1 || e == 17 || e == 18) begin
                n_run++;
                if ({qpll_ready, state} !== ((e == 1) ? {1'b0, 3'd1} : (e == 17) ? {1'b0, 3'd4} : {1'b1, 3'd5})) begin
                    n_fail++;
                    $display("FAIL async_seq_pt e=%0d got=%b/%0d", e, qpll_ready, state);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, qpll_lock ? 59 : 9) == 0) qpll_lock = ~qpll_lock;
            if ($urandom_range(0, qpll_refclk_lost ? 7 : 149) == 0) qpll_refclk_lost = ~qpll_refclk_lost;
            @(posedge clk); #1;
            n_run++;
            if (dut_vec !== mexp) begin
                n_fail++;
                $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec, mexp);
            end
        end
        start = 1'b0;
        qpll_refclk_lost = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_nominal();
        test_never_lock();
        test_glitch();
        test_refclk_loss();
        test_start();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
